// File: rtl/ysyx_23060061_axil_pkg.sv
// Shared constants for the N-master AXI-Lite arbiter.
// FSM state codes and AXI response codes.
package ysyx_23060061_axil_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060061_rr_picker.sv
// Rotating-priority one-hot picker.
// Search starts at i_ptr; ptr tied to 0 gives lowest-index-first.
module ysyx_23060061_rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  // first requester at or after the pointer, wrapping around
  always_comb begin : p_pick
    logic          hit;
    logic [PW-1:0] j;
    o_gnt = '0;
    hit   = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(i_ptr) + k) % N);
      if (!hit && i_req[j]) begin
        o_gnt[j] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060061_axil_nway_arbiter.sv
// N-master to 1-slave AXI-Lite arbiter, one transaction per grant.
// Define AXIL_ARB_RR_EN for round-robin; otherwise fixed priority.
module ysyx_23060061_axil_nway_arbiter
  import ysyx_23060061_axil_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST*AW-1:0]     m_araddr,
  input  logic [N_MST*AW-1:0]     m_awaddr,
  input  logic [N_MST-1:0]        m_arvalid,
  input  logic [N_MST-1:0]        m_awvalid,
  input  logic [N_MST-1:0]        m_wvalid,
  input  logic [N_MST-1:0]        m_rready,
  input  logic [N_MST-1:0]        m_bready,
  input  logic [N_MST*DW-1:0]     m_wdata,
  input  logic [N_MST*DW/8-1:0]   m_wstrb,
  output logic [N_MST-1:0]        m_arready,
  output logic [N_MST-1:0]        m_awready,
  output logic [N_MST-1:0]        m_wready,
  output logic [N_MST-1:0]        m_rvalid,
  output logic [N_MST-1:0]        m_bvalid,
  output logic [DW-1:0]           m_rdata,
  output logic [1:0]              m_rresp,
  output logic [1:0]              m_bresp,
  output logic [AW-1:0]           araddr,
  output logic [AW-1:0]           awaddr,
  output logic [DW-1:0]           wdata,
  output logic [DW/8-1:0]         wstrb,
  output logic                    arvalid,
  output logic                    awvalid,
  output logic                    wvalid,
  output logic                    rready,
  output logic                    bready,
  input  logic                    arready,
  input  logic                    awready,
  input  logic                    wready,
  input  logic                    rvalid,
  input  logic                    bvalid,
  input  logic [DW-1:0]           rdata,
  input  logic [1:0]              rresp,
  input  logic [1:0]              bresp,
  output logic [N_MST-1:0]        grant
);

  localparam int IW = $clog2(N_MST);
  localparam int SW = DW / 8;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [N_MST-1:0] r_grant;
  logic [N_MST-1:0] w_grant_nxt;
  logic             r_ar_done;
  logic             r_aw_done;
  logic             r_w_done;
  logic             w_ar_done_nxt;
  logic             w_aw_done_nxt;
  logic             w_w_done_nxt;
  logic [N_MST-1:0] w_req;
  logic [N_MST-1:0] w_pick;
  logic [IW-1:0]    w_own;
  logic [IW-1:0]    w_ptr;
  logic             w_ar_hs;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_r_hs;
  logic             w_b_hs;

  assign w_req = m_arvalid | (m_awvalid & m_wvalid);
  assign grant = r_grant;

`ifdef AXIL_ARB_RR_EN
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW-1:0] w_win;

  assign w_ptr = r_ptr;

  // index of the master chosen this cycle
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (w_pick[i]) w_win = IW'(i);
    end
  end
`else
  assign w_ptr = '0;
`endif

  ysyx_23060061_rr_picker #(
    .N (N_MST)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_pick)
  );

  // index of the current owner
  always_comb begin
    w_own = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (r_grant[i]) w_own = IW'(i);
    end
  end

  assign w_ar_hs = arvalid & arready;
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_r_hs  = rvalid & rready;
  assign w_b_hs  = bvalid & bready;

  // state, grant, done flags and pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef AXIL_ARB_RR_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ar_done <= w_ar_done_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
`ifdef AXIL_ARB_RR_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

  // arbitration and per-channel completion tracking
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ar_done_nxt = r_ar_done;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
`ifdef AXIL_ARB_RR_EN
    w_ptr_nxt     = r_ptr;
`endif
    unique case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_nxt   = w_pick;
          w_state_nxt   = (|(m_arvalid & w_pick)) ? RD : WR;
          w_ar_done_nxt = 1'b0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
`ifdef AXIL_ARB_RR_EN
          w_ptr_nxt = (w_win == IW'(N_MST - 1)) ? '0 : w_win + 1'b1;
`endif
        end
      end
      RD: begin
        if (w_ar_hs) w_ar_done_nxt = 1'b1;
        if (w_r_hs) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_ar_done_nxt = 1'b0;
        end
      end
      WR: begin
        if (w_aw_hs) w_aw_done_nxt = 1'b1;
        if (w_w_hs)  w_w_done_nxt  = 1'b1;
        if (w_b_hs) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_grant_nxt   = '0;
        w_ar_done_nxt = 1'b0;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
      end
    endcase
  end

  // channel forwarding between owner and slave
  always_comb begin
    m_arready = '0;
    m_awready = '0;
    m_wready  = '0;
    m_rvalid  = '0;
    m_bvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_bresp   = '0;
    araddr    = '0;
    awaddr    = '0;
    wdata     = '0;
    wstrb     = '0;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;
    unique case (r_state)
      RD: begin
        araddr           = m_araddr[int'(w_own)*AW +: AW];
        arvalid          = m_arvalid[w_own] & ~r_ar_done;
        rready           = m_rready[w_own];
        m_arready[w_own] = arready & ~r_ar_done;
        m_rvalid[w_own]  = rvalid;
        m_rdata          = rdata;
        m_rresp          = rresp;
      end
      WR: begin
        awaddr           = m_awaddr[int'(w_own)*AW +: AW];
        wdata            = m_wdata[int'(w_own)*DW +: DW];
        wstrb            = m_wstrb[int'(w_own)*SW +: SW];
        awvalid          = m_awvalid[w_own] & ~r_aw_done;
        wvalid           = m_wvalid[w_own] & ~r_w_done;
        bready           = m_bready[w_own];
        m_awready[w_own] = awready & ~r_aw_done;
        m_wready[w_own]  = wready & ~r_w_done;
        m_bvalid[w_own]  = bvalid;
        m_bresp          = bresp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060061_axil_nway_arbiter.sv
// Bench for the N-way AXI-Lite arbiter (N_MST=3).
// Directed scenarios plus random traffic against a transaction model.
module tb_ysyx_23060061_axil_nway_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXIL_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N-1:0] m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0] m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [DW-1:0] m_rdata;
  logic [1:0] m_rresp, m_bresp;
  logic [AW-1:0] araddr, awaddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic arvalid, awvalid, wvalid, rready, bready;
  logic arready, awready, wready, rvalid, bvalid;
  logic [DW-1:0] rdata;
  logic [1:0] rresp, bresp;
  logic [N-1:0] grant;

  int checks = 0;
  int errors = 0;

  // transaction-level model: owner (-1 idle), kind, channel completion
  int mo = -1;
  int mk = 0;
  bit mard = 0, mawd = 0, mwd = 0;
  int mptr = 0;

  always #5 clk = ~clk;

  ysyx_23060061_axil_nway_arbiter #(.N_MST(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_awaddr(m_awaddr),
    .m_arvalid(m_arvalid), .m_awvalid(m_awvalid), .m_wvalid(m_wvalid),
    .m_rready(m_rready), .m_bready(m_bready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_arready(m_arready), .m_awready(m_awready), .m_wready(m_wready),
    .m_rvalid(m_rvalid), .m_bvalid(m_bvalid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
    .araddr(araddr), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .arvalid(arvalid), .awvalid(awvalid), .wvalid(wvalid),
    .rready(rready), .bready(bready),
    .arready(arready), .awready(awready), .wready(wready),
    .rvalid(rvalid), .bvalid(bvalid),
    .rdata(rdata), .rresp(rresp), .bresp(bresp),
    .grant(grant)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int base);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (base + k) % N;
      if (w < 0 && (m_arvalid[j] || (m_awvalid[j] && m_wvalid[j]))) w = j;
    end
    return w;
  endfunction

  // per-cycle comparison against the model, then model advance
  always @(negedge clk) begin : p_model
    logic [N-1:0] e_arr, e_awr, e_wr, e_rv, e_bv, e_g;
    logic [AW-1:0] e_ara, e_awa;
    logic [DW-1:0] e_wd, e_rd;
    logic [SW-1:0] e_ws;
    logic [1:0] e_rr, e_br;
    logic e_arv, e_awv, e_wv, e_rrdy, e_brdy;
    int w;
    e_arr = '0; e_awr = '0; e_wr = '0; e_rv = '0; e_bv = '0; e_g = '0;
    e_ara = '0; e_awa = '0; e_wd = '0; e_rd = '0; e_ws = '0;
    e_rr = '0; e_br = '0;
    e_arv = 0; e_awv = 0; e_wv = 0; e_rrdy = 0; e_brdy = 0;
    if (mo >= 0) begin
      e_g[mo] = 1'b1;
      if (mk == 0) begin
        e_ara = m_araddr[mo*AW +: AW];
        e_arv = m_arvalid[mo] && !mard;
        e_rrdy = m_rready[mo];
        e_arr[mo] = arready && !mard;
        e_rv[mo] = rvalid;
        e_rd = rdata;
        e_rr = rresp;
      end else begin
        e_awa = m_awaddr[mo*AW +: AW];
        e_wd = m_wdata[mo*DW +: DW];
        e_ws = m_wstrb[mo*SW +: SW];
        e_awv = m_awvalid[mo] && !mawd;
        e_wv = m_wvalid[mo] && !mwd;
        e_brdy = m_bready[mo];
        e_awr[mo] = awready && !mawd;
        e_wr[mo] = wready && !mwd;
        e_bv[mo] = bvalid;
        e_br = bresp;
      end
    end
    chk("m_grant", 64'(grant), 64'(e_g));
    chk("m_araddr", 64'(araddr), 64'(e_ara));
    chk("m_awaddr", 64'(awaddr), 64'(e_awa));
    chk("m_wdata", 64'({wstrb, wdata}), 64'({e_ws, e_wd}));
    chk("m_slv_ctl", 64'({arvalid, awvalid, wvalid, rready, bready}),
        64'({e_arv, e_awv, e_wv, e_rrdy, e_brdy}));
    chk("m_mst_rdy", 64'({m_arready, m_awready, m_wready}),
        64'({e_arr, e_awr, e_wr}));
    chk("m_mst_rsp", 64'({m_rvalid, m_bvalid, m_rresp, m_bresp}),
        64'({e_rv, e_bv, e_rr, e_br}));
    chk("m_rdata", 64'(m_rdata), 64'(e_rd));
    if (rst) begin
      mo = -1; mard = 0; mawd = 0; mwd = 0; mptr = 0;
    end else if (mo < 0) begin
      w = pick(RR ? mptr : 0);
      if (w >= 0) begin
        mo = w;
        mk = m_arvalid[w] ? 0 : 1;
        mard = 0; mawd = 0; mwd = 0;
        mptr = (w + 1) % N;
      end
    end else if (mk == 0) begin
      if (e_arv && arready) mard = 1;
      if (rvalid && m_rready[mo]) begin
        mo = -1; mard = 0;
      end
    end else begin
      if (e_awv && awready) mawd = 1;
      if (e_wv && wready) mwd = 1;
      if (bvalid && m_bready[mo]) begin
        mo = -1; mawd = 0; mwd = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic clr_in;
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
    m_rready = '0; m_bready = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; bresp = '0;
  endtask

  task automatic do_reset;
    tick;
    clr_in;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask

  initial begin
    int got[$];
    logic [N-1:0] prev;

    // reset with every input high
    rst = 1;
    m_araddr = '1; m_awaddr = '1; m_wdata = '1; m_wstrb = '1;
    m_arvalid = '1; m_awvalid = '1; m_wvalid = '1;
    m_rready = '1; m_bready = '1;
    arready = 1; awready = 1; wready = 1; rvalid = 1; bvalid = 1;
    rdata = '1; rresp = '1; bresp = '1;
    tick;
    tick;
    samp;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_slv_ctl", 64'({arvalid, awvalid, wvalid, rready, bready}), 0);
    chk("rst_mst", 64'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_data", {wdata, m_rdata}, 0);
    clr_in;
    rst = 0;
    tick;
    tick;
    samp;
    chk("idle_grant", 64'(grant), 0);

    // single read by master 1
    tick;
    m_arvalid[1] = 1;
    m_araddr[1*AW +: AW] = 32'h8000_0004;
    m_rready[1] = 1;
    tick;
    arready = 1;
    samp;
    chk("rd_grant", 64'(grant), 64'(3'b010));
    chk("rd_arvalid", 64'(arvalid), 1);
    chk("rd_araddr", 64'(araddr), 64'h8000_0004);
    chk("rd_m_arready", 64'(m_arready), 64'(3'b010));
    tick;
    arready = 0;
    samp;
    chk("rd_arvalid_forced", 64'(arvalid), 0);
    tick;
    rvalid = 1;
    rdata = 32'hDEAD_BEEF;
    m_arvalid = '0;
    samp;
    chk("rd_m_rvalid", 64'(m_rvalid), 64'(3'b010));
    chk("rd_m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    tick;
    rvalid = 0;
    rdata = '0;
    samp;
    chk("rd_release", 64'(grant), 0);

    // write by master 0, W before AW
    tick;
    clr_in;
    m_awvalid[0] = 1;
    m_wvalid[0] = 1;
    m_awaddr[0 +: AW] = 32'h8000_0010;
    m_wdata[0 +: DW] = 32'h1234_5678;
    m_wstrb[0 +: SW] = 4'hF;
    m_bready[0] = 1;
    tick;
    wready = 1;
    samp;
    chk("wr_grant", 64'(grant), 64'(3'b001));
    chk("wr_valids", 64'({awvalid, wvalid, arvalid}), 64'(3'b110));
    chk("wr_wdata", 64'({wstrb, wdata}), 64'({4'hF, 32'h1234_5678}));
    chk("wr_m_wready", 64'(m_wready), 64'(3'b001));
    tick;
    wready = 0;
    awready = 1;
    samp;
    chk("wr_w_forced", 64'({awvalid, wvalid}), 64'(2'b10));
    chk("wr_awaddr", 64'(awaddr), 64'h8000_0010);
    chk("wr_m_awready", 64'({m_awready, m_wready}), 64'(6'b001000));
    tick;
    awready = 0;
    bvalid = 1;
    bresp = 2'b00;
    m_awvalid = '0;
    m_wvalid = '0;
    samp;
    chk("wr_b_fwd", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    chk("wr_m_bvalid", 64'({m_bvalid, m_bresp}), 64'({3'b001, 2'b00}));
    tick;
    bvalid = 0;
    samp;
    chk("wr_release", 64'(grant), 0);

    // read and write together from master 2: read first
    tick;
    clr_in;
    m_arvalid[2] = 1;
    m_awvalid[2] = 1;
    m_wvalid[2] = 1;
    m_rready[2] = 1;
    m_bready[2] = 1;
    m_araddr[2*AW +: AW] = 32'h100;
    m_awaddr[2*AW +: AW] = 32'h200;
    tick;
    arready = 1;
    rvalid = 1;
    rresp = 2'b10;
    samp;
    chk("both_rd_first", 64'({grant, arvalid, awvalid, wvalid}),
        64'({3'b100, 3'b100}));
    chk("both_rresp", 64'({m_rvalid, m_rresp}), 64'({3'b100, 2'b10}));
    tick;
    arready = 0;
    rvalid = 0;
    rresp = 0;
    m_arvalid = '0;
    samp;
    chk("both_gap", 64'(grant), 0);
    tick;
    awready = 1;
    wready = 1;
    bvalid = 1;
    bresp = 2'b11;
    samp;
    chk("both_wr_next", 64'({grant, arvalid, awvalid, wvalid}),
        64'({3'b100, 3'b011}));
    chk("both_bresp", 64'({m_bvalid, m_bresp}), 64'({3'b100, 2'b11}));
    tick;
    clr_in;
    samp;
    chk("both_release", 64'(grant), 0);

    // reset in WR after aw_done
    tick;
    m_awvalid[0] = 1;
    m_wvalid[0] = 1;
    m_bready[0] = 1;
    tick;
    awready = 1;
    tick;
    awready = 0;
    rst = 1;
    samp;
    chk("wrst_aw_done", 64'({awvalid, wvalid}), 64'(2'b01));
    tick;
    rst = 0;
    samp;
    chk("wrst_grant", 64'(grant), 0);
    chk("wrst_outs", 64'({arvalid, awvalid, wvalid, bready, m_awready, m_wready}), 0);
    tick;
    samp;
    chk("wrst_regrant", 64'({grant, awvalid, wvalid}), 64'({3'b001, 2'b11}));

    // contention: all masters keep reading
    do_reset;
    m_arvalid = '1;
    m_rready = '1;
    arready = 1;
    rvalid = 1;
    prev = '0;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      samp;
      if (grant != 0 && prev == 0) got.push_back($clog2(grant));
      prev = grant;
      tick;
    end
    chk("cont_count", 64'(got.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("cont_order%0d", i),
          64'(i < got.size() ? got[i] : 99), 64'(RR ? i % N : 0));

    // random traffic
    do_reset;
    for (int c = 0; c < 4000; c++) begin
      tick;
      rst = ($urandom_range(0, 299) == 0);
      m_araddr = {$urandom, $urandom, $urandom};
      m_awaddr = {$urandom, $urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom};
      m_wstrb = N*SW'($urandom);
      for (int i = 0; i < N; i++) begin
        m_arvalid[i] = ($urandom_range(0, 9) < 3);
        m_awvalid[i] = ($urandom_range(0, 9) < 5);
        m_wvalid[i] = ($urandom_range(0, 9) < 5);
        m_rready[i] = $urandom_range(0, 1) == 1;
        m_bready[i] = $urandom_range(0, 1) == 1;
      end
      arready = $urandom_range(0, 1) == 1;
      awready = $urandom_range(0, 1) == 1;
      wready = $urandom_range(0, 1) == 1;
      rvalid = ($urandom_range(0, 9) < 3);
      bvalid = ($urandom_range(0, 9) < 3);
      rdata = $urandom;
      rresp = 2'($urandom);
      bresp = 2'($urandom);
    end
    tick;
    clr_in;
    samp;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
